// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix display path.
// Holds the sequencer FSM encoding, the ASCII characters it emits, and the default dimension limit.
package matrix_pkg;

    localparam int unsigned MAX_DIM_DEFAULT = 5;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRdWait,
        StConv,
        StEmit,
        StAck,
        StWaitTx,
        StNext
    } state_e;

endpackage

// File: rtl/matrix_tx_sequencer_if.sv
// Bundles the sequencer's control inputs, its storage read port, its UART TX byte port and its status.
// The master side is the sequencer; the slave side is the surrounding logic.
interface matrix_tx_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [2:0]        rows;
    logic [2:0]        cols;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, base_addr, rows, cols, mem_rd_data, tx_busy,
        output mem_rd_en, mem_rd_addr, tx_data, tx_start, busy, done, err
    );

    modport slave (
        output start, base_addr, rows, cols, mem_rd_data, tx_busy,
        input  mem_rd_en, mem_rd_addr, tx_data, tx_start, busy, done, err
    );
endinterface

// File: rtl/byte_to_dec_ascii.sv
// Combinational unsigned byte to decimal ASCII converter.
// Always produces all three digit characters; ndigits tells how many are significant (1..3).
module byte_to_dec_ascii
    import matrix_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] hundreds,
    output logic [7:0] tens,
    output logic [7:0] ones,
    output logic [1:0] ndigits
);

    logic [7:0] h_val;
    logic [7:0] t_val;
    logic [7:0] o_val;

    always_comb begin
        h_val    = value / 8'd100;
        t_val    = (value / 8'd10) % 8'd10;
        o_val    = value % 8'd10;
        hundreds = CH_ZERO + h_val;
        tens     = CH_ZERO + t_val;
        ones     = CH_ZERO + o_val;
        if (value >= 8'd100) begin
            ndigits = 2'd3;
        end else if (value >= 8'd10) begin
            ndigits = 2'd2;
        end else begin
            ndigits = 2'd1;
        end
    end

endmodule

// File: rtl/matrix_tx_sequencer.sv
// Streams a stored row-major matrix over the UART TX byte interface as decimal ASCII,
// one element per read, separated by spaces with CR LF at the end of each row.
module matrix_tx_sequencer
    import matrix_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned MAX_DIM = MAX_DIM_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    matrix_tx_sequencer_if.master bus
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] ptr_q;
    logic [2:0]        r_q, c_q, rows_q, cols_q;
    logic [DATA_W-1:0] elem_q;
    logic [7:0]        dig0_q, dig1_q, dig2_q;
    logic [1:0]        nd_q;
    logic [2:0]        idx_q;
    logic              err_q, done_q;

    logic [7:0] conv_in;
    logic [7:0] conv_h, conv_t, conv_o;
    logic [1:0] conv_nd;
    logic       dims_legal;
    logic       last_col, last_row;
    logic [2:0] nchars;
    logic       more_chars;
    logic [7:0] cur_char;

    assign conv_in = 8'(elem_q);

    byte_to_dec_ascii u_conv (
        .value    (conv_in),
        .hundreds (conv_h),
        .tens     (conv_t),
        .ones     (conv_o),
        .ndigits  (conv_nd)
    );

    assign dims_legal = (bus.rows != 3'd0) && (32'(bus.rows) <= MAX_DIM) &&
                        (bus.cols != 3'd0) && (32'(bus.cols) <= MAX_DIM);
    assign last_col   = (c_q == cols_q - 3'd1);
    assign last_row   = (r_q == rows_q - 3'd1);
    // Digits plus separator: one space, or CR LF at the end of a row.
    assign nchars     = {1'b0, nd_q} + (last_col ? 3'd2 : 3'd1);
    assign more_chars = (idx_q + 3'd1) < nchars;

    always_comb begin
        cur_char = CH_LF;
        if (idx_q < {1'b0, nd_q}) begin
            case (idx_q[1:0])
                2'd0:    cur_char = dig0_q;
                2'd1:    cur_char = dig1_q;
                default: cur_char = dig2_q;
            endcase
        end else if (idx_q == {1'b0, nd_q}) begin
            cur_char = last_col ? CH_CR : CH_SPACE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (bus.start && dims_legal) state_d = StRd;
            StRd:     state_d = StRdWait;
            StRdWait: state_d = StConv;
            StConv:   state_d = StEmit;
            StEmit:   state_d = StAck;
            StAck:    state_d = StWaitTx;
            StWaitTx: if (!bus.tx_busy) state_d = StNext;
            StNext: begin
                if (more_chars) begin
                    state_d = StEmit;
                end else if (last_col && last_row) begin
                    state_d = StIdle;
                end else begin
                    state_d = StRd;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            r_q    <= '0;
            c_q    <= '0;
            rows_q <= '0;
            cols_q <= '0;
            elem_q <= '0;
            dig0_q <= '0;
            dig1_q <= '0;
            dig2_q <= '0;
            nd_q   <= '0;
            idx_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (dims_legal) begin
                            err_q  <= 1'b0;
                            ptr_q  <= bus.base_addr;
                            r_q    <= '0;
                            c_q    <= '0;
                            rows_q <= bus.rows;
                            cols_q <= bus.cols;
                            idx_q  <= '0;
                        end else begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end
                    end
                end
                StRdWait: elem_q <= bus.mem_rd_data;
                StConv: begin
                    // Pack significant digits MS-first so idx 0 is always the first char.
                    nd_q <= conv_nd;
                    if (conv_nd == 2'd3) begin
                        dig0_q <= conv_h;
                        dig1_q <= conv_t;
                        dig2_q <= conv_o;
                    end else if (conv_nd == 2'd2) begin
                        dig0_q <= conv_t;
                        dig1_q <= conv_o;
                        dig2_q <= conv_o;
                    end else begin
                        dig0_q <= conv_o;
                        dig1_q <= conv_o;
                        dig2_q <= conv_o;
                    end
                end
                StNext: begin
                    if (more_chars) begin
                        idx_q <= idx_q + 3'd1;
                    end else begin
                        idx_q <= '0;
                        if (last_col && last_row) begin
                            done_q <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                            if (last_col) begin
                                c_q <= '0;
                                r_q <= r_q + 3'd1;
                            end else begin
                                c_q <= c_q + 3'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy        = (state_q != StIdle);
        bus.mem_rd_en   = (state_q == StRd);
        bus.mem_rd_addr = ptr_q;
        bus.tx_start    = (state_q == StEmit);
        bus.tx_data     = (state_q == StEmit) ? cur_char : 8'h00;
        bus.done        = done_q;
        bus.err         = err_q;
    end

endmodule
